// File: rtl/aes_dec_key_sched_if.sv
// Round-key request/response bundle between the AES-128 decrypt key scheduler and its consumer.
// Key load and round-key handshake travel together; the scheduler side uses the slave modport.
interface aes_dec_key_sched_if;
    logic         start_in;
    logic [127:0] key_in;
    logic         rk_req_in;
    logic         rewind_in;
    logic         busy_out;
    logic         rk_valid_out;
    logic [127:0] rk_out;
    logic [3:0]   rk_round_out;
    logic         rk_last_out;

    modport master (
        output start_in, key_in, rk_req_in, rewind_in,
        input  busy_out, rk_valid_out, rk_out, rk_round_out, rk_last_out
    );

    modport slave (
        input  start_in, key_in, rk_req_in, rewind_in,
        output busy_out, rk_valid_out, rk_out, rk_round_out, rk_last_out
    );
endinterface

// File: rtl/aes_dec_key_sched.sv
// AES-128 decrypt round-key generator: expands in 50 cycles with one shared S-box, then serves keys 10..0.
// One key per cycle on rk_req_in; rk_out holds while the consumer stalls; start_in restarts from any state.
module aes_dec_key_sched #(
    parameter int NR             = 10,
    parameter bit REWIND_ON_LAST = 1'b1
) (
    input logic clk,
    input logic reset,
    aes_dec_key_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXPAND, SERVE} state_t;

    localparam logic [3:0] LAST_RND = 4'(NR);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t       state, state_nxt;
    logic [127:0] mem [0:NR];
    logic [127:0] cur_key;
    logic [31:0]  t;
    logic [7:0]   rcon;
    logic [3:0]   round;
    logic [2:0]   step;
    logic [3:0]   index;
    logic         busy;
    logic         rk_valid;
    logic [127:0] rk;
    logic [3:0]   rk_round;

    logic [31:0]  rot_w3, tr, w0n, w1n, w2n, w3n;
    logic [127:0] next_key;
    logic [7:0]   sbox_in, sbox_out, rcon_nxt;
    logic         hs, do_rewind, round_store, expand_done;

    assign rot_w3 = {cur_key[23:0], cur_key[31:24]};

    always_comb begin
        sbox_in = rot_w3[31:24];
        case (step[1:0])
            2'd1:    sbox_in = rot_w3[23:16];
            2'd2:    sbox_in = rot_w3[15:8];
            2'd3:    sbox_in = rot_w3[7:0];
            default: sbox_in = rot_w3[31:24];
        endcase
    end

    assign sbox_out = SBOX[sbox_in];

    assign tr       = t ^ {rcon, 24'h0};
    assign w0n      = cur_key[127:96] ^ tr;
    assign w1n      = cur_key[95:64]  ^ w0n;
    assign w2n      = cur_key[63:32]  ^ w1n;
    assign w3n      = cur_key[31:0]   ^ w2n;
    assign next_key = {w0n, w1n, w2n, w3n};
    assign rcon_nxt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

    assign round_store = (state == EXPAND) && (step == 3'd4);
    assign expand_done = round_store && (round == LAST_RND);
    assign hs          = (state == SERVE) && bus.rk_req_in && rk_valid;
    assign do_rewind   = (state == SERVE) && bus.rewind_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.start_in) begin
            state_nxt = EXPAND;
        end else begin
            case (state)
                EXPAND:  if (expand_done) state_nxt = SERVE;
                SERVE:   if (!do_rewind && hs && index == 4'd0 && !REWIND_ON_LAST) state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    // Key buffer needs no reset: it is always rewritten before being served.
    always_ff @(posedge clk) begin
        if (bus.start_in)     mem[0]     <= bus.key_in;
        else if (round_store) mem[round] <= next_key;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_key  <= '0;
            t        <= '0;
            rcon     <= '0;
            round    <= '0;
            step     <= '0;
            index    <= '0;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            rk       <= '0;
            rk_round <= '0;
        end else if (bus.start_in) begin
            cur_key  <= bus.key_in;
            rcon     <= 8'h01;
            round    <= 4'd1;
            step     <= 3'd0;
            busy     <= 1'b1;
            rk_valid <= 1'b0;
        end else if (state == EXPAND) begin
            if (step != 3'd4) begin
                case (step[1:0])
                    2'd0: t[31:24] <= sbox_out;
                    2'd1: t[23:16] <= sbox_out;
                    2'd2: t[15:8]  <= sbox_out;
                    2'd3: t[7:0]   <= sbox_out;
                    default: t     <= t;
                endcase
                step <= step + 3'd1;
            end else begin
                cur_key <= next_key;
                rcon    <= rcon_nxt;
                round   <= round + 4'd1;
                step    <= 3'd0;
                if (round == LAST_RND) begin
                    busy     <= 1'b0;
                    rk_valid <= 1'b1;
                    index    <= LAST_RND;
                    rk       <= next_key;
                    rk_round <= LAST_RND;
                end
            end
        end else if (state == SERVE) begin
            if (do_rewind) begin
                index    <= LAST_RND;
                rk       <= mem[LAST_RND];
                rk_round <= LAST_RND;
            end else if (hs) begin
                if (index != 4'd0) begin
                    index    <= index - 4'd1;
                    rk       <= mem[index - 4'd1];
                    rk_round <= index - 4'd1;
                end else if (REWIND_ON_LAST) begin
                    index    <= LAST_RND;
                    rk       <= mem[LAST_RND];
                    rk_round <= LAST_RND;
                end else begin
                    rk_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.busy_out     = busy;
    assign bus.rk_valid_out = rk_valid;
    assign bus.rk_out       = rk;
    assign bus.rk_round_out = rk_round;
    assign bus.rk_last_out  = rk_valid && (rk_round == 4'd0);
endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Bench for aes_dec_key_sched: two instances (wrap / stop on last key) against a GF(2^8) key-expansion model.
module tb_aes_dec_key_sched;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    aes_dec_key_sched_if ifa ();
    aes_dec_key_sched_if ifb ();

    aes_dec_key_sched #(.NR(10), .REWIND_ON_LAST(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    aes_dec_key_sched #(.NR(10), .REWIND_ON_LAST(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0]   sb [256];
    logic [127:0] exp_rk [11];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
        return 8'((b << k) | (b >> (8 - k)));
    endfunction

    // S-box from first principles: multiplicative inverse in GF(2^8) followed by the affine map.
    task automatic build_sbox();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (v != 0 && gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
            sb[v] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_key(input bit sel, input logic [127:0] key);
        if (sel) begin ifb.start_in = 1'b1; ifb.key_in = key; end
        else     begin ifa.start_in = 1'b1; ifa.key_in = key; end
        tick();
        ifa.start_in = 1'b0;
        ifb.start_in = 1'b0;
    endtask

    task automatic wait_valid(input bit sel, output int lat);
        lat = -1;
        for (int c = 1; c <= 120; c++) begin
            tick();
            if (sel ? ifb.rk_valid_out : ifa.rk_valid_out) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        ifa.start_in = 0; ifa.key_in = '0; ifa.rk_req_in = 0; ifa.rewind_in = 0;
        ifb.start_in = 0; ifb.key_in = '0; ifb.rk_req_in = 0; ifb.rewind_in = 0;
        reset = 1'b1;
        tick(); tick();
        n_cmp++; if (ifa.busy_out !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", ifa.busy_out); end
        n_cmp++; if (ifa.rk_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ifa.rk_valid_out); end
        n_cmp++; if (ifa.rk_out !== 128'h0) begin n_err++; $display("FAIL reset_rk: got %h want 0", ifa.rk_out); end
        n_cmp++; if (ifa.rk_round_out !== 4'd0) begin n_err++; $display("FAIL reset_round: got %0d want 0", ifa.rk_round_out); end
        n_cmp++; if (ifa.rk_last_out !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b want 0", ifa.rk_last_out); end
        n_cmp++; if (ifb.rk_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid_b: got %b want 0", ifb.rk_valid_out); end
        reset = 1'b0;
        ifa.rk_req_in = 1'b1; ifa.rewind_in = 1'b1;
        tick(); tick();
        n_cmp++; if (ifa.rk_valid_out !== 1'b0 || ifa.busy_out !== 1'b0) begin
            n_err++; $display("FAIL idle_ignores_req: got valid=%b busy=%b want 0 0", ifa.rk_valid_out, ifa.busy_out); end
        ifa.rk_req_in = 1'b0; ifa.rewind_in = 1'b0;
    endtask

    task automatic test_latency();
        int lat;
        logic [127:0] key;
        key = 128'h000102030405060708090a0b0c0d0e0f;
        model_expand(key);
        start_key(1'b0, key);
        n_cmp++; if (ifa.busy_out !== 1'b1) begin n_err++; $display("FAIL t1_busy: got %b want 1", ifa.busy_out); end
        wait_valid(1'b0, lat);
        n_cmp++; if (lat !== 50) begin n_err++; $display("FAIL t1_latency: got %0d want 50", lat); end
        n_cmp++; if (ifa.busy_out !== 1'b0) begin n_err++; $display("FAIL t1_busy_done: got %b want 0", ifa.busy_out); end
        n_cmp++; if (ifa.rk_out !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
            n_err++; $display("FAIL t1_rk10: got %h want 13111d7fe3944a17f307a78b4d2b30c5", ifa.rk_out); end
        n_cmp++; if (ifa.rk_out !== exp_rk[10]) begin n_err++; $display("FAIL t1_rk10_model: got %h want %h", ifa.rk_out, exp_rk[10]); end
        n_cmp++; if (ifa.rk_round_out !== 4'd10) begin n_err++; $display("FAIL t1_round: got %0d want 10", ifa.rk_round_out); end
    endtask

    task automatic test_stream();
        logic [127:0] key;
        int lat, r;
        for (int k = 0; k < 4; k++) begin
            key = (k == 0) ? 128'h2b7e151628aed2a6abf7158809cf4f3c : {$urandom, $urandom, $urandom, $urandom};
            model_expand(key);
            start_key(1'b0, key);
            wait_valid(1'b0, lat);
            n_cmp++; if (lat !== 50) begin n_err++; $display("FAIL t2_latency k=%0d: got %0d want 50", k, lat); end
            ifa.rk_req_in = 1'b1;
            for (int i = 0; i < 13; i++) begin
                r = (i <= 10) ? 10 - i : 21 - i;
                n_cmp++; if (ifa.rk_round_out !== 4'(r) || ifa.rk_out !== exp_rk[r]) begin
                    n_err++; $display("FAIL t2_key k=%0d i=%0d: got r%0d %h want r%0d %h", k, i, ifa.rk_round_out, ifa.rk_out, r, exp_rk[r]); end
                n_cmp++; if (ifa.rk_last_out !== (r == 0)) begin
                    n_err++; $display("FAIL t2_last k=%0d i=%0d: got %b want %b", k, i, ifa.rk_last_out, r == 0); end
                if (k == 0 && r == 9) begin
                    n_cmp++; if (ifa.rk_out !== 128'hac7766f319fadc2128d12941575c006e) begin
                        n_err++; $display("FAIL t2_fips_r9: got %h want ac7766f319fadc2128d12941575c006e", ifa.rk_out); end
                end
                if (k == 0 && r == 0) begin
                    n_cmp++; if (ifa.rk_out !== key) begin n_err++; $display("FAIL t2_fips_r0: got %h want %h", ifa.rk_out, key); end
                end
                tick();
            end
            ifa.rk_req_in = 1'b0;
        end
    endtask

    task automatic test_no_rewind();
        logic [127:0] key;
        int lat;
        key = {$urandom, $urandom, $urandom, $urandom};
        model_expand(key);
        start_key(1'b1, key);
        wait_valid(1'b1, lat);
        n_cmp++; if (lat !== 50) begin n_err++; $display("FAIL t3_latency: got %0d want 50", lat); end
        ifb.rk_req_in = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            n_cmp++; if (ifb.rk_valid_out !== 1'b1 || ifb.rk_round_out !== 4'(10 - i) || ifb.rk_out !== exp_rk[10-i]) begin
                n_err++; $display("FAIL t3_key i=%0d: got v%b r%0d %h want v1 r%0d %h", i, ifb.rk_valid_out, ifb.rk_round_out, ifb.rk_out, 10 - i, exp_rk[10-i]); end
            tick();
        end
        n_cmp++; if (ifb.rk_valid_out !== 1'b0 || ifb.rk_last_out !== 1'b0 || ifb.busy_out !== 1'b0) begin
            n_err++; $display("FAIL t3_idle: got v%b l%b b%b want 0 0 0", ifb.rk_valid_out, ifb.rk_last_out, ifb.busy_out); end
        tick();
        n_cmp++; if (ifb.rk_valid_out !== 1'b0) begin n_err++; $display("FAIL t3_stays_idle: got %b want 0", ifb.rk_valid_out); end
        ifb.rk_req_in = 1'b0;
    endtask

    task automatic test_restart();
        logic [127:0] key1, key2, rk10_old;
        int lat;
        key1 = {$urandom, $urandom, $urandom, $urandom};
        key2 = {$urandom, $urandom, $urandom, $urandom};
        model_expand(key1);
        rk10_old = exp_rk[10];
        model_expand(key2);
        start_key(1'b0, key1);
        for (int i = 1; i < 20; i++) tick();
        start_key(1'b0, key2);
        wait_valid(1'b0, lat);
        n_cmp++; if (lat !== 50) begin n_err++; $display("FAIL t4_latency: got %0d want 50", lat); end
        n_cmp++; if (ifa.rk_out !== exp_rk[10]) begin n_err++; $display("FAIL t4_new_key: got %h want %h", ifa.rk_out, exp_rk[10]); end
        n_cmp++; if (ifa.rk_out === rk10_old) begin n_err++; $display("FAIL t4_stale_key: got %h want not %h", ifa.rk_out, rk10_old); end
    endtask

    task automatic test_async_reset();
        int lat;
        start_key(1'b0, {$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 25; i++) tick();
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (ifa.busy_out !== 1'b0 || ifa.rk_valid_out !== 1'b0) begin
            n_err++; $display("FAIL t5_expand_reset: got busy=%b valid=%b want 0 0", ifa.busy_out, ifa.rk_valid_out); end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        n_cmp++; if (ifa.rk_valid_out !== 1'b0 || ifa.busy_out !== 1'b0) begin
            n_err++; $display("FAIL t5_no_resume: got valid=%b busy=%b want 0 0", ifa.rk_valid_out, ifa.busy_out); end
        model_expand(128'h000102030405060708090a0b0c0d0e0f);
        start_key(1'b0, 128'h000102030405060708090a0b0c0d0e0f);
        wait_valid(1'b0, lat);
        ifa.rk_req_in = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (ifa.rk_round_out !== 4'd7 || ifa.rk_out !== exp_rk[7]) begin
            n_err++; $display("FAIL t5_serve: got r%0d %h want r7 %h", ifa.rk_round_out, ifa.rk_out, exp_rk[7]); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (ifa.rk_valid_out !== 1'b0 || ifa.rk_out !== 128'h0 || ifa.rk_round_out !== 4'd0 || ifa.rk_last_out !== 1'b0) begin
            n_err++; $display("FAIL t5_serve_reset: got v%b %h r%0d l%b want all 0", ifa.rk_valid_out, ifa.rk_out, ifa.rk_round_out, ifa.rk_last_out); end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++; if (ifa.rk_valid_out !== 1'b0) begin n_err++; $display("FAIL t5_stale_valid: got %b want 0", ifa.rk_valid_out); end
        ifa.rk_req_in = 1'b0;
    endtask

    task automatic test_rewind();
        int lat;
        model_expand({$urandom, $urandom, $urandom, $urandom});
        start_key(1'b0, exp_rk[0]);
        ifa.rk_req_in = 1'b1;
        ifa.rewind_in = 1'b1;
        for (int i = 0; i < 45; i++) tick();
        ifa.rewind_in = 1'b0;
        wait_valid(1'b0, lat);
        n_cmp++; if (lat + 45 !== 50) begin n_err++; $display("FAIL t6_latency: got %0d want 50", lat + 45); end
        n_cmp++; if (ifa.rk_round_out !== 4'd10 || ifa.rk_out !== exp_rk[10]) begin
            n_err++; $display("FAIL t6_first: got r%0d %h want r10 %h", ifa.rk_round_out, ifa.rk_out, exp_rk[10]); end
        for (int i = 0; i < 6; i++) tick();
        n_cmp++; if (ifa.rk_round_out !== 4'd4 || ifa.rk_out !== exp_rk[4]) begin
            n_err++; $display("FAIL t6_round4: got r%0d %h want r4 %h", ifa.rk_round_out, ifa.rk_out, exp_rk[4]); end
        ifa.rewind_in = 1'b1;
        tick();
        ifa.rewind_in = 1'b0;
        n_cmp++; if (ifa.rk_round_out !== 4'd10 || ifa.rk_out !== exp_rk[10]) begin
            n_err++; $display("FAIL t6_rewind: got r%0d %h want r10 %h", ifa.rk_round_out, ifa.rk_out, exp_rk[10]); end
        tick();
        ifa.rk_req_in = 1'b0;
        n_cmp++; if (ifa.rk_round_out !== 4'd9 || ifa.rk_out !== exp_rk[9]) begin
            n_err++; $display("FAIL t6_after_rewind: got r%0d %h want r9 %h", ifa.rk_round_out, ifa.rk_out, exp_rk[9]); end
        tick(); tick();
        n_cmp++; if (ifa.rk_round_out !== 4'd9 || ifa.rk_out !== exp_rk[9] || ifa.rk_valid_out !== 1'b1) begin
            n_err++; $display("FAIL t6_hold: got v%b r%0d %h want v1 r9 %h", ifa.rk_valid_out, ifa.rk_round_out, ifa.rk_out, exp_rk[9]); end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_latency();
        test_stream();
        test_no_rewind();
        test_restart();
        test_async_reset();
        test_rewind();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
